// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and movement arithmetic for the PS/2 mouse front end.
package ps2_pkg;

    // Device-to-host frame: start, 8 data bits, odd parity, stop.
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 3;

    // Header byte (packet byte 0) bit positions.
    localparam int unsigned HDR_L    = 0;
    localparam int unsigned HDR_R    = 1;
    localparam int unsigned HDR_M    = 2;
    localparam int unsigned HDR_SYNC = 3;
    localparam int unsigned HDR_XS   = 4;
    localparam int unsigned HDR_YS   = 5;
    localparam int unsigned HDR_XO   = 6;
    localparam int unsigned HDR_YO   = 7;

    // Position of the next expected byte inside a 3-byte packet.
    typedef enum logic [1:0] {
        IDX_HDR = 2'd0,
        IDX_X   = 2'd1,
        IDX_Y   = 2'd2
    } byte_idx_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // 9-bit two's complement movement; an overflowed axis is pinned to its extreme.
    function automatic logic [8:0] make_delta(input logic sign, input logic ovf,
                                              input logic [7:0] mag);
        if (ovf) begin
            return sign ? 9'h100 : 9'h0FF;
        end
        return {sign, mag};
    endfunction

    // 10-bit sum covers -256..510, so bit 9 flags negative and bit 8 flags > 255.
    function automatic logic [7:0] sat_add(input logic [7:0] pos, input logic [8:0] delta);
        logic [9:0] sum;
        sum = {2'b00, pos} + {delta[8], delta};
        if (sum[9]) begin
            return '0;
        end
        if (sum[8]) begin
            return '1;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: pin conditioning, falling-edge detection and frame FSM.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned BIT_TIMEOUT = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (BIT_TIMEOUT > 1) ? $clog2(BIT_TIMEOUT) : 1;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fe;
    rx_state_t     state, state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          timeout, parity_ok;
    logic          shift_en, parity_en, done_set, err_set;

    assign timeout   = (state != RX_IDLE) && !fe && (tmo_cnt == TW'(BIT_TIMEOUT - 1));
    assign parity_ok = ^{shift, par_bit};

    // Two-flop synchronisers, preset to the idle-high line level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {clk_s1, clk_s2, dat_s1, dat_s2} <= '1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: follow the pin only after FILTER_LEN consecutive differing samples; strobe fe on 1->0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
                fe       <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM next-state logic; a bad start bit simply leaves the receiver idle
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (fe && !dat_s2) state_next = RX_DATA;
            end
            RX_DATA: begin
                if (timeout) state_next = RX_IDLE;
                else if (fe && (bit_cnt == 3'(DATA_BITS - 1))) state_next = RX_PARITY;
            end
            RX_PARITY: begin
                if (timeout) state_next = RX_IDLE;
                else if (fe) state_next = RX_STOP;
            end
            RX_STOP: begin
                if (timeout || fe) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Frame FSM outputs: datapath enables and the byte/error verdict at the stop bit
    always_comb begin
        shift_en  = 1'b0;
        parity_en = 1'b0;
        done_set  = 1'b0;
        err_set   = timeout;
        case (state)
            RX_DATA:   shift_en  = fe;
            RX_PARITY: parity_en = fe;
            RX_STOP: begin
                if (fe) begin
                    if (dat_s2 && parity_ok) done_set = 1'b1;
                    else err_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Receive datapath: LSB-first shifting, parity capture, bit timer and registered result pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            byte_done <= 1'b0;
            byte_data <= '0;
            err       <= 1'b0;
        end else begin
            byte_done <= done_set;
            err       <= err_set;
            if (done_set) byte_data <= shift;
            if (state == RX_IDLE) bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift <= {dat_s2, shift[7:1]};
            if (parity_en) par_bit <= dat_s2;
            if ((state == RX_IDLE) || fe) tmo_cnt <= '0;
            else tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_mouse_position.sv
// PS/2 mouse packet assembler and saturating absolute X/Y position accumulator.
module ps2_mouse_position
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned BIT_TIMEOUT = 10000,
    parameter int unsigned PKT_TIMEOUT = 100000,
    parameter logic [7:0]  X_INIT      = 8'd128,
    parameter logic [7:0]  Y_INIT      = 8'd128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] XPosition,
    output logic [7:0] YPosition,
    output logic [2:0] buttons,
    output logic       packet_valid,
    output logic       frame_err
);

    localparam int unsigned PW = (PKT_TIMEOUT > 1) ? $clog2(PKT_TIMEOUT) : 1;

    // The clock frequency only documents the cycle-based timeouts; zero means a broken override.
    if (CLK_HZ == 0) begin : g_bad_clk_hz
        $error("ps2_mouse_position: CLK_HZ must be non-zero");
    end

    logic          byte_done;
    logic [7:0]    rx_byte;
    byte_idx_t     idx;
    logic [7:0]    hdr, xbyte;
    logic [PW-1:0] pkt_cnt;
    logic          pkt_timeout;

    ps2_rx_byte #(
        .FILTER_LEN (FILTER_LEN),
        .BIT_TIMEOUT(BIT_TIMEOUT)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_done(byte_done),
        .byte_data(rx_byte),
        .err      (frame_err)
    );

    assign pkt_timeout = (idx != IDX_HDR) && !byte_done && (pkt_cnt == PW'(PKT_TIMEOUT - 1));

    // Inter-byte timer, running only while a packet is partially assembled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt <= '0;
        end else if ((idx == IDX_HDR) || byte_done) begin
            pkt_cnt <= '0;
        end else begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    // Packet assembly and position update; errors and timeouts share one index reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx          <= IDX_HDR;
            hdr          <= '0;
            xbyte        <= '0;
            XPosition    <= X_INIT;
            YPosition    <= Y_INIT;
            buttons      <= '0;
            packet_valid <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            if (frame_err || pkt_timeout) begin
                idx <= IDX_HDR;
            end else if (byte_done) begin
                case (idx)
                    IDX_HDR: begin
                        if (rx_byte[HDR_SYNC]) begin
                            hdr <= rx_byte;
                            idx <= IDX_X;
                        end
                    end
                    IDX_X: begin
                        xbyte <= rx_byte;
                        idx   <= IDX_Y;
                    end
                    IDX_Y: begin
                        XPosition    <= sat_add(XPosition, make_delta(hdr[HDR_XS], hdr[HDR_XO], xbyte));
                        YPosition    <= sat_add(YPosition, make_delta(hdr[HDR_YS], hdr[HDR_YO], rx_byte));
                        buttons      <= {hdr[HDR_M], hdr[HDR_R], hdr[HDR_L]};
                        packet_valid <= 1'b1;
                        idx          <= IDX_HDR;
                    end
                    default: idx <= IDX_HDR;
                endcase
            end
        end
    end

endmodule

// File: doc/ps2_mouse_position.md
Name: ps2_mouse_position

Overview:
- Receive-only PS/2 mouse front end for the Basys-2 display path.
- Deserialises device-to-host PS/2 frames and assembles standard 3-byte stream-mode packets.
- Integrates the signed X/Y movement into saturating 8-bit absolute positions.
- Drives the XPosition/YPosition inputs of the downstream seven-segment position display; device enabling (0xF4) is done by a separate init block.

Parameters:
- CLK_HZ, 50000000, system clock frequency; documentation only, the timeouts below are in cycles.
- FILTER_LEN, 8, consecutive equal synchronised ps2_clk samples needed before the filtered clock changes.
- BIT_TIMEOUT, 10000, cycles (200 us) allowed between falling edges inside one frame.
- PKT_TIMEOUT, 100000, cycles (2 ms) allowed between bytes of one packet.
- X_INIT, 8'd128, XPosition reset value.
- Y_INIT, 8'd128, YPosition reset value.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- XPosition  out  8  accumulated X position, 0..255.
- YPosition  out  8  accumulated Y position, 0..255; increases for upward motion.
- buttons  out  3  {middle, right, left} from the last valid packet.
- packet_valid  out  1  one-cycle pulse; high in the same cycle the positions and buttons take new values.
- frame_err  out  1  one-cycle pulse on parity error, stop error or bit timeout.

Behaviour:
- Reset, async active-high, all outputs:
  - XPosition=X_INIT, YPosition=Y_INIT, buttons=0, packet_valid=0, frame_err=0.
  - Receiver goes to IDLE; byte index = 0; synchroniser and filter registers preset to 1 (line idle).
  - Reset asserted mid-frame or mid-packet discards all partial data.
- Input conditioning:
  - Both pins pass a 2-flop synchroniser.
  - The filtered clock changes only after FILTER_LEN identical samples.
  - A falling edge of the filtered clock = "fe", a one-cycle strobe. ps2_data (synchronised) is sampled on fe.
- Byte receiver FSM (sub-module), states IDLE, DATA, PARITY, STOP:
  - IDLE: on fe, if data=0 go to DATA with bit count 0; if data=1 (bad start bit) stay in IDLE, no error.
  - DATA: 8 fe events, LSB first, into a shift register; then PARITY.
  - PARITY: sample the parity bit; odd parity over data plus parity bit must hold.
  - STOP: sample the stop bit.
    - Stop=1 and parity ok: byte_done pulses in the next cycle with the byte.
    - Otherwise: frame_err pulses in the next cycle and no byte is produced.
    - Either way, return to IDLE.
  - In DATA, PARITY or STOP, BIT_TIMEOUT cycles without fe -> frame_err pulse, go to IDLE.
- Packet assembler:
  - Byte index 0: accept the byte only if bit3=1 (sync bit); otherwise drop it silently and stay at index 0.
  - Header fields: b0 L, b1 R, b2 M, b4 X sign, b5 Y sign, b6 X overflow, b7 Y overflow.
  - Index 1 = X magnitude byte, index 2 = Y byte.
  - dx = 9-bit two's complement {Xsign, byte1}; dy likewise with byte2.
  - If an overflow bit is set, that delta is forced to +255 (sign 0) or -256 (sign 1).
  - Any frame_err, or PKT_TIMEOUT cycles between bytes while index != 0, returns the index to 0 and discards the partial packet.
- Update, in the cycle after byte_done of byte index 2:
  - XPosition = clamp(XPosition + dx, 0, 255), computed in 10-bit signed arithmetic; YPosition likewise with dy.
  - buttons are latched from the header.
  - packet_valid = 1 for exactly that cycle.
- Latency: the 11th (stop) fe -> byte_done at +1 cycle -> positions and packet_valid at +2 cycles.
- Simultaneous events:
  - A timeout and fe in the same cycle: fe wins and the timeout counter clears.
  - frame_err and a pending packet timeout in the same cycle: a single index reset.
- Hold: positions hold indefinitely between packets; there is no drift and no wrap-around.

Decomposition:
- Package ps2_pkg holds:
  - The frame bit count (11).
  - The header bit indices (L=0, R=1, M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7).
  - Byte index constants.
  - The receiver state encoding.
- One sub-module, ps2_rx_byte: synchroniser, glitch filter, fe detection, frame FSM and bit timeout. Its outputs are byte_done, byte[7:0] and err.
- The top level contains the packet assembler and the saturating accumulator.

Test Plan:
- Reset, then packet 0x08, 0x05, 0x03 at 12 kHz -> XPosition=133, YPosition=131, buttons=0, one packet_valid 2 cycles after the last stop-bit fe.
- From 128, packet 0x39, 0xF6, 0x80 -> dx=-10, dy=-128 -> X=118, Y=0; buttons=3'b001.
- From X=250, packet 0x48, 0x00, 0x00 (X overflow, positive) -> X=255 saturated, Y unchanged.
- Byte 0x08 sent with bad parity -> frame_err pulse, no packet_valid; the following good 3-byte packet updates normally.
- Two bytes of a packet, then a 3 ms gap, then a fresh packet 0x08, 0x01, 0x01 -> a single update of X+1, Y+1; the stale bytes are never used.
- Clock glitch (3-cycle low pulse) on ps2_clk mid-frame -> ignored by the filter, byte received correctly. Separately, stop clocking after 4 bits -> frame_err after 10000 cycles.
